load_wb_ctrl: RTL and testbench

Load-writeback controller between the execute stage, the data cache read port and the register-file write port (A3/WD3/WE3). It accepts one load at a time, issues a word-aligned read to the cache, waits any number of cycles for `mem_ready`, then extracts and extends the byte, half or word and writes it to the destination register. It merges load writebacks with single-cycle ALU writebacks on the one write port and raises `stall` on conflicts or hazards.

---
 rtl/rv_load_pkg.sv | 30 +++
 rtl/load_extend.sv | 27 ++
 rtl/load_wb_ctrl.sv | 106 ++++++++++
 tb/tb_load_wb_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_load_pkg.sv
// Shared load-path definitions: funct3 encodings, controller states and
// the legality/alignment check used when a load is accepted.
package rv_load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // True only for a legal funct3 whose access fits its natural alignment
    function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = (off[0] == 1'b0);
            F3_LW:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word from a little-endian cache word and
// sign- or zero-extends it according to the load funct3.
module load_extend
    import rv_load_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[8*off +: 8];
        sel_half = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   ext = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  ext = {24'd0, sel_byte};
            F3_LH:   ext = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  ext = {16'd0, sel_half};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/load_wb_ctrl.sv
// Load-writeback controller: one outstanding cache read at a time, merged
// with single-cycle ALU writebacks onto the single register-file write port.
module load_wb_ctrl
    import rv_load_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_addr,
    input  logic [2:0]        ld_funct3,
    input  logic              alu_we,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_wd,
    output logic              mem_rd_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              WE3,
    output logic [REG_AW-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              stall,
    output logic              busy_valid,
    output logic [REG_AW-1:0] busy_rd,
    output logic              ld_err
);

    state_t            state;
    logic [REG_AW-1:0] rd_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] ext_data;

    load_extend u_extend (
        .word   (data_q),
        .off    (off_q),
        .funct3 (f3_q),
        .ext    (ext_data)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            rd_q     <= '0;
            off_q    <= '0;
            f3_q     <= F3_LW;
            data_q   <= '0;
            mem_addr <= '0;
            ld_err   <= 1'b0;
        end else begin
            ld_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld_valid) begin
                        if (load_ok(ld_funct3, ld_addr[1:0])) begin
                            state    <= S_REQ;
                            rd_q     <= ld_rd;
                            off_q    <= ld_addr[1:0];
                            f3_q     <= ld_funct3;
                            mem_addr <= {ld_addr[DATA_W-1:2], 2'b00};
                        end else begin
                            ld_err <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        data_q <= mem_rdata;
                        state  <= S_WB;
                    end
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ld_ready   = (state == S_IDLE);
    assign mem_rd_req = (state == S_REQ);
    assign busy_valid = (state != S_IDLE);
    assign busy_rd    = rd_q;

    // The load owns the port in WB; in REQ an ALU write to the pending rd
    // would be overwritten out of order, so it is held back instead.
    always_comb begin
        WE3   = alu_we && (alu_rd != '0);
        A3    = alu_rd;
        WD3   = alu_wd;
        stall = ld_valid && !ld_ready;
        if (state == S_WB) begin
            WE3   = (rd_q != '0);
            A3    = rd_q;
            WD3   = ext_data;
            stall = stall || alu_we;
        end else if (state == S_REQ && alu_we && alu_rd == rd_q && alu_rd != '0) begin
            WE3   = 1'b0;
            stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_load_wb_ctrl.sv
// Directed self-checking bench for load_wb_ctrl; inputs change 1ns after the
// rising edge and outputs are compared before the next one.
module tb_load_wb_ctrl;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_addr = '0;
    logic [2:0]  ld_funct3 = '0;
    logic        alu_we = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_wd = '0;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        stall;
    logic        busy_valid;
    logic [4:0]  busy_rd;
    logic        ld_err;

    int checks = 0;
    int failures = 0;

    load_wb_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .RST(RST),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
        .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .stall(stall), .busy_valid(busy_valid), .busy_rd(busy_rd), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one load for a cycle, waits delay REQ cycles, then returns the
    // write-port values seen in WB and the number of writes in the 3 cycles after.
    task automatic run_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] rdata, input int delay,
                            output logic we, output logic [4:0] a3, output logic [31:0] wd,
                            output int held_bad, output int writes);
        ld_valid = 1'b1; ld_rd = rd; ld_addr = addr; ld_funct3 = f3;
        step();
        ld_valid = 1'b0;
        mem_rdata = 32'h1234_5678;
        held_bad = 0;
        for (int i = 0; i <= delay; i++) begin
            if (!(mem_rd_req === 1'b1 && mem_addr === {addr[31:2], 2'b00} &&
                  busy_valid === 1'b1 && busy_rd === rd && WE3 === 1'b0))
                held_bad++;
            if (i < delay) step();
        end
        mem_ready = 1'b1; mem_rdata = rdata;
        step();
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        we = WE3; a3 = A3; wd = WD3;
        writes = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (WE3 === 1'b1) writes++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({mem_rd_req, WE3, ld_err, busy_valid, stall} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b required 00000", {mem_rd_req, WE3, ld_err, busy_valid, stall});
        end
        checks++;
        if (mem_addr !== 32'd0 || A3 !== 5'd0 || WD3 !== 32'd0 || busy_rd !== 5'd0 || ld_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_values: got addr=%h A3=%0d WD3=%h busy_rd=%0d ready=%b required 0/0/0/0/1",
                     mem_addr, A3, WD3, busy_rd, ld_ready);
        end
        step();
        RST = 1'b1;
        step();
    endtask

    task automatic test_lw_hit();
        logic we; logic [4:0] a3; logic [31:0] wd; int hb, wr;
        run_load(5'd5, 32'h100, 3'b010, 32'hDEAD_BEEF, 0, we, a3, wd, hb, wr);
        checks++;
        if (we !== 1'b1 || a3 !== 5'd5 || wd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL lw_hit: got we=%b A3=%0d WD3=%h required 1/5/deadbeef", we, a3, wd);
        end
        checks++;
        if (hb !== 0 || wr !== 0 || ld_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lw_hit_req: got held_bad=%0d extra_writes=%0d ready=%b required 0/0/1", hb, wr, ld_ready);
        end
    endtask

    task automatic test_extend();
        logic we; logic [4:0] a3; logic [31:0] wd; int hb, wr;
        logic [2:0]  f3s [5]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] adrs [5]  = '{32'h103, 32'h103, 32'h102, 32'h200, 32'h301};
        logic [31:0] rds [5]   = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_1234, 32'h1234_F00D, 32'h0000_7F00};
        logic [31:0] exps [5]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F00D, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            run_load(5'd3, adrs[i], f3s[i], rds[i], 0, we, a3, wd, hb, wr);
            checks++;
            if (we !== 1'b1 || a3 !== 5'd3 || wd !== exps[i]) begin
                failures++;
                $display("[TB] FAIL extend_%0d: got we=%b A3=%0d WD3=%h required 1/3/%h", i, we, a3, wd, exps[i]);
            end
        end
    endtask

    task automatic test_miss();
        logic we; logic [4:0] a3; logic [31:0] wd; int hb, wr;
        run_load(5'd12, 32'h0000_4ABE, 3'b101, 32'hCAFE_0001, 7, we, a3, wd, hb, wr);
        checks++;
        if (hb !== 0) begin
            failures++;
            $display("[TB] FAIL miss_hold: got %0d unstable REQ cycles required 0", hb);
        end
        checks++;
        if (we !== 1'b1 || a3 !== 5'd12 || wd !== 32'h0000_CAFE || wr !== 0) begin
            failures++;
            $display("[TB] FAIL miss_write: got we=%b A3=%0d WD3=%h extra=%0d required 1/12/0000cafe/0", we, a3, wd, wr);
        end
    endtask

    task automatic test_errors();
        logic [2:0]  f3s [3]  = '{3'b010, 3'b011, 3'b001};
        logic [31:0] adrs [3] = '{32'h101, 32'h100, 32'h103};
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_rd = 5'd9; ld_addr = adrs[i]; ld_funct3 = f3s[i];
            step();
            ld_valid = 1'b0;
            checks++;
            if (ld_err !== 1'b1 || mem_rd_req !== 1'b0 || busy_valid !== 1'b0 || WE3 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL err_%0d: got err=%b req=%b busy=%b we=%b required 1/0/0/0", i, ld_err, mem_rd_req, busy_valid, WE3);
            end
            step();
            checks++;
            if (ld_err !== 1'b0 || mem_rd_req !== 1'b0 || WE3 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL err_pulse_%0d: got err=%b req=%b we=%b required 0/0/0", i, ld_err, mem_rd_req, WE3);
            end
        end
    endtask

    task automatic test_rd_zero();
        logic we; logic [4:0] a3; logic [31:0] wd; int hb, wr;
        run_load(5'd0, 32'h80, 3'b010, 32'h5555_AAAA, 1, we, a3, wd, hb, wr);
        checks++;
        if (hb !== 0 || we !== 1'b0 || wr !== 0) begin
            failures++;
            $display("[TB] FAIL rd_zero: got held_bad=%0d we=%b extra=%0d required 0/0/0", hb, we, wr);
        end
    endtask

    task automatic test_alu_merge();
        ld_valid = 1'b1; ld_rd = 5'd5; ld_addr = 32'h40; ld_funct3 = 3'b010;
        step();
        checks++;
        if (stall !== 1'b1 || ld_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_stall: got stall=%b ready=%b required 1/0", stall, ld_ready);
        end
        ld_valid = 1'b0;
        alu_we = 1'b1; alu_rd = 5'd7; alu_wd = 32'h0000_AAAA;
        #1;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h0000_AAAA || stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_pass_req: got we=%b A3=%0d WD3=%h stall=%b required 1/7/0000aaaa/0", WE3, A3, WD3, stall);
        end
        alu_rd = 5'd5; alu_wd = 32'h0000_BBBB;
        #1;
        checks++;
        if (WE3 !== 1'b0 || stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL alu_waw: got we=%b stall=%b required 0/1", WE3, stall);
        end
        mem_ready = 1'b1; mem_rdata = 32'h0102_0304;
        step();
        mem_ready = 1'b0;
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h0102_0304 || stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wb_priority: got we=%b A3=%0d WD3=%h stall=%b required 1/5/01020304/1", WE3, A3, WD3, stall);
        end
        step();
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h0000_BBBB || stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_after_wb: got we=%b A3=%0d WD3=%h stall=%b required 1/5/0000bbbb/0", WE3, A3, WD3, stall);
        end
        alu_rd = 5'd0;
        #1;
        checks++;
        if (WE3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_x0: got we=%b required 0", WE3);
        end
        alu_we = 1'b0; alu_rd = '0; alu_wd = '0;
        step();
    endtask

    task automatic test_reset_mid();
        int wr;
        ld_valid = 1'b1; ld_rd = 5'd6; ld_addr = 32'h44; ld_funct3 = 3'b010;
        step();
        ld_valid = 1'b0;
        RST = 1'b0;
        #1;
        checks++;
        if (mem_rd_req !== 1'b0 || busy_valid !== 1'b0 || ld_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid: got req=%b busy=%b ready=%b required 0/1 idle", mem_rd_req, busy_valid, ld_ready);
        end
        mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        #3;
        RST = 1'b1;
        wr = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (WE3 === 1'b1 || mem_rd_req === 1'b1) wr++;
        end
        mem_ready = 1'b0;
        checks++;
        if (wr !== 0) begin
            failures++;
            $display("[TB] FAIL reset_drop: got %0d write/req cycles required 0", wr);
        end
    endtask

    initial begin
        test_reset();
        test_lw_hit();
        test_extend();
        test_miss();
        test_errors();
        test_rd_zero();
        test_alu_merge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
